xillybus_rd_stream_bridge: RTL and testbench

- Bridges an HLS process ap_fifo output port (din/full_n/write) to a Xillybus FPGA-to-CPU read stream (user_r_*: rden/empty/data/eof/open).
- Replaces the external FIFO and ad-hoc output register at the tail of the process chain.
- Buffers producer words internally and presents them with Xillybus read timing.
- Generates a frame-terminating EOF after a programmable word count.

---
 rtl/xillybus_rd_stream_bridge.sv | 167 ++++++++++++++++
 tb/tb_xillybus_rd_stream_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_rd_stream_bridge.sv
// xillybus_rd_stream_bridge
// Buffers words from an HLS ap_fifo output port and serves them to a Xillybus
// FPGA-to-CPU read stream. Optionally ends each frame with a one-cycle EOF pulse
// after frame_len words. frame_len = 0 gives an endless stream.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | device file closed; nothing offered to the host, writes accepted
// STREAM    | file open; words offered while the buffer is non-empty
// EOF_PULSE | last word of the frame is on user_r_data; user_r_eof high
// DONE      | frame delivered; waiting for the host to close the file
module xillybus_rd_stream_bridge #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FRAME_WIDTH-1:0] frame_len,
    input  logic [DATA_WIDTH-1:0]  in_V_din,
    output logic                   in_V_full_n,
    input  logic                   in_V_write,
    input  logic                   user_r_rden,
    output logic                   user_r_empty,
    output logic [DATA_WIDTH-1:0]  user_r_data,
    output logic                   user_r_eof,
    input  logic                   user_r_open,
    output logic [ADDR_WIDTH:0]    level,
    output logic                   drop_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        EOF_PULSE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH:0]    count;
    logic [FRAME_WIDTH-1:0] remaining;

    logic                   buf_full;
    logic                   wr_accept;
    logic                   rd_accept;
    logic                   last_word;

    // Full is taken from the registered count only, so a read in the same
    // cycle never lets a write through at full.
    assign buf_full    = (count == FULL_COUNT);
    assign in_V_full_n = !reset && !buf_full;
    assign wr_accept   = in_V_write && in_V_full_n;
    assign rd_accept   = user_r_rden && !user_r_empty;
    assign level       = count;

    // remaining == 0 inside STREAM means an endless stream, so only a framed
    // read can reach the 1 -> 0 transition.
    assign last_word   = rd_accept && (remaining == FRAME_WIDTH'(1));

    // Host-facing flags decoded from the state; reset forces the idle view.
    always_comb begin
        user_r_empty = 1'b1;
        user_r_eof   = 1'b0;
        case (state)
            STREAM:    user_r_empty = (count == '0);
            EOF_PULSE: user_r_eof   = 1'b1;
            default:   ;
        endcase
        if (reset) begin
            user_r_empty = 1'b1;
            user_r_eof   = 1'b0;
        end
    end

    // Next-state logic; closing the file always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (user_r_open)
                    state_next = STREAM;
            end
            STREAM: begin
                if (!user_r_open)
                    state_next = IDLE;
                else if (last_word)
                    state_next = EOF_PULSE;
            end
            EOF_PULSE: begin
                state_next = user_r_open ? DONE : IDLE;
            end
            DONE: begin
                if (!user_r_open)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Frame word counter: loaded on open, counts down on each framed read.
    always_ff @(posedge clk) begin
        if (reset)
            remaining <= '0;
        else if (state == IDLE && user_r_open)
            remaining <= frame_len;
        else if (state == STREAM && rd_accept && remaining != '0)
            remaining <= remaining - FRAME_WIDTH'(1);
    end

    // Buffer storage; contents are not reset, the pointers discard them.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= in_V_din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_accept)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: ;
            endcase
        end
    end

    // Read data register: loads on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset)
            user_r_data <= '0;
        else if (rd_accept)
            user_r_data <= mem[rd_ptr];
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            drop_err <= 1'b0;
        else if (in_V_write && buf_full)
            drop_err <= 1'b1;
    end

endmodule

// File: tb/tb_xillybus_rd_stream_bridge.sv
// Testbench for xillybus_rd_stream_bridge: directed vector table, hand-written
// corner sequences and a randomized run, all checked against a queue-based
// reference model.
module tb_xillybus_rd_stream_bridge;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int FW    = 16;
    localparam int DEPTH = 16;

    localparam int P_IDLE   = 0;
    localparam int P_STREAM = 1;
    localparam int P_EOF    = 2;
    localparam int P_DONE   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [FW-1:0] frame_len;
    logic [DW-1:0] in_V_din;
    logic          in_V_full_n;
    logic          in_V_write;
    logic          user_r_rden;
    logic          user_r_empty;
    logic [DW-1:0] user_r_data;
    logic          user_r_eof;
    logic          user_r_open;
    logic [AW:0]   level;
    logic          drop_err;

    always #5 clk = ~clk;

    xillybus_rd_stream_bridge #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_WIDTH(FW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_len   (frame_len),
        .in_V_din    (in_V_din),
        .in_V_full_n (in_V_full_n),
        .in_V_write  (in_V_write),
        .user_r_rden (user_r_rden),
        .user_r_empty(user_r_empty),
        .user_r_data (user_r_data),
        .user_r_eof  (user_r_eof),
        .user_r_open (user_r_open),
        .level       (level),
        .drop_err    (drop_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic          open;
        logic [FW-1:0] flen;
        logic          wr;
        logic [DW-1:0] din;
        logic          rden;
        logic          e_empty;
        logic          e_full_n;
        logic          e_eof;
        int            e_level;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tab[$];

    // reference model: buffer as a queue plus a session phase and word budget
    logic [DW-1:0] mq[$];
    int            phase;
    int            left;
    logic [DW-1:0] m_data;
    logic          m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic open, input logic [FW-1:0] flen,
                       input logic wr, input logic [DW-1:0] din, input logic rden,
                       input logic e_empty, input logic e_full_n, input logic e_eof,
                       input int e_level, input logic [DW-1:0] e_data);
        vec_t v;
        v.rst = rst; v.open = open; v.flen = flen; v.wr = wr; v.din = din; v.rden = rden;
        v.e_empty = e_empty; v.e_full_n = e_full_n; v.e_eof = e_eof;
        v.e_level = e_level; v.e_data = e_data;
        tab.push_back(v);
    endtask

    // One clock cycle: drive inputs, compare outputs before the edge, then
    // advance the model across the edge.
    task automatic apply(input vec_t v, input bit tab_chk);
        logic x_full_n, x_empty, x_eof, rd_ok, wr_ok, hit;
        reset = v.rst; user_r_open = v.open; frame_len = v.flen;
        in_V_write = v.wr; in_V_din = v.din; user_r_rden = v.rden;
        #1;
        x_full_n = !v.rst && (mq.size() != DEPTH);
        x_empty  = v.rst || !(phase == P_STREAM && mq.size() != 0);
        x_eof    = !v.rst && (phase == P_EOF);
        chk("full_n",   64'(in_V_full_n),  64'(x_full_n));
        chk("empty",    64'(user_r_empty), 64'(x_empty));
        chk("eof",      64'(user_r_eof),   64'(x_eof));
        chk("level",    64'(level),        64'(mq.size()));
        chk("data",     64'(user_r_data),  64'(m_data));
        chk("drop_err", 64'(drop_err),     64'(m_drop));
        if (tab_chk) begin
            chk("tab_empty",  64'(user_r_empty), 64'(v.e_empty));
            chk("tab_full_n", 64'(in_V_full_n),  64'(v.e_full_n));
            chk("tab_eof",    64'(user_r_eof),   64'(v.e_eof));
            chk("tab_level",  64'(level),        64'(v.e_level));
            chk("tab_data",   64'(user_r_data),  64'(v.e_data));
        end
        rd_ok = v.rden && !x_empty;
        wr_ok = v.wr && x_full_n;
        hit   = 1'b0;
        @(posedge clk);
        #1;
        if (v.rst) begin
            mq.delete();
            phase  = P_IDLE;
            left   = 0;
            m_data = '0;
            m_drop = 1'b0;
        end else begin
            if (v.wr && !x_full_n) m_drop = 1'b1;
            if (rd_ok) m_data = mq.pop_front();
            if (wr_ok) mq.push_back(v.din);
            case (phase)
                P_IDLE: if (v.open) begin left = int'(v.flen); phase = P_STREAM; end
                P_STREAM: begin
                    if (rd_ok && left != 0) begin left--; hit = (left == 0); end
                    if (!v.open) phase = P_IDLE;
                    else if (hit) phase = P_EOF;
                end
                P_EOF:   phase = v.open ? P_DONE : P_IDLE;
                default: if (!v.open) phase = P_IDLE;
            endcase
        end
    endtask

    task automatic cyc(input logic rst, input logic open, input logic [FW-1:0] flen,
                       input logic wr, input logic [DW-1:0] din, input logic rden);
        vec_t v;
        v.rst = rst; v.open = open; v.flen = flen; v.wr = wr; v.din = din; v.rden = rden;
        v.e_empty = 1'b0; v.e_full_n = 1'b0; v.e_eof = 1'b0; v.e_level = 0; v.e_data = '0;
        apply(v, 1'b0);
    endtask

    initial begin
        int eof_cnt;
        logic [DW-1:0] eof_data;
        logic          r_open;
        logic [FW-1:0] r_flen;

        mq.delete();
        phase = P_IDLE; left = 0; m_data = '0; m_drop = 1'b0;

        // priming reset edge so the DUT starts from a known state
        reset = 1'b1; user_r_open = 1'b0; frame_len = '0;
        in_V_write = 1'b0; in_V_din = '0; user_r_rden = 1'b0;
        @(posedge clk);
        #1;

        // reset / idle
        add(1,0,0,0,0,0, 1,0,0,0,0);
        add(1,0,0,0,0,0, 1,0,0,0,0);
        add(1,0,0,0,0,0, 1,0,0,0,0);
        add(0,0,0,0,0,0, 1,1,0,0,0);
        // basic endless stream
        add(0,1,0,0,0,0,     1,1,0,0,0);
        add(0,1,0,1,'h11,0,  1,1,0,0,0);
        add(0,1,0,1,'h22,0,  0,1,0,1,0);
        add(0,1,0,1,'h33,0,  0,1,0,2,0);
        add(0,1,0,0,0,1,     0,1,0,3,0);
        add(0,1,0,0,0,1,     0,1,0,2,'h11);
        add(0,1,0,0,0,1,     0,1,0,1,'h22);
        add(0,1,0,0,0,1,     1,1,0,0,'h33);
        add(0,0,0,0,0,0,     1,1,0,0,'h33);
        // frame of 4 words with 6 buffered
        add(0,1,4,1,'hA0,0,  1,1,0,0,'h33);
        add(0,1,4,1,'hA1,0,  0,1,0,1,'h33);
        add(0,1,4,1,'hA2,0,  0,1,0,2,'h33);
        add(0,1,4,1,'hA3,0,  0,1,0,3,'h33);
        add(0,1,4,1,'hA4,0,  0,1,0,4,'h33);
        add(0,1,4,1,'hA5,0,  0,1,0,5,'h33);
        add(0,1,4,0,0,1,     0,1,0,6,'h33);
        add(0,1,4,0,0,1,     0,1,0,5,'hA0);
        add(0,1,4,0,0,1,     0,1,0,4,'hA1);
        add(0,1,4,0,0,1,     0,1,0,3,'hA2);
        add(0,1,4,0,0,1,     1,1,1,2,'hA3);
        add(0,1,4,0,0,1,     1,1,0,2,'hA3);
        add(0,0,4,0,0,0,     1,1,0,2,'hA3);
        add(0,1,4,0,0,0,     1,1,0,2,'hA3);
        add(0,1,4,0,0,1,     0,1,0,2,'hA3);
        add(0,1,4,0,0,1,     0,1,0,1,'hA4);
        add(0,1,4,0,0,1,     1,1,0,0,'hA5);
        add(0,0,4,0,0,0,     1,1,0,0,'hA5);

        foreach (tab[i]) apply(tab[i], 1'b1);

        // full boundary with pointer wrap, closed file
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, DW'(i), 0);
        chk("full_drop_err", 64'(drop_err), 64'(1));
        chk("full_level",    64'(level),    64'(16));
        chk("full_full_n",   64'(in_V_full_n), 64'(0));
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 'h99, 1);
        chk("full_rw_level", 64'(level),       64'(15));
        chk("full_rw_data",  64'(user_r_data), 64'(0));
        for (int i = 1; i < 16; i++) begin
            cyc(0, 1, 0, 0, 0, 1);
            chk("wrap_order", 64'(user_r_data), 64'(i));
        end

        // simultaneous write+read at level 1, then rden while empty
        cyc(0, 1, 0, 1, 'h100, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 1, DW'('h101 + k), 1);
            chk("rw_level", 64'(level),       64'(1));
            chk("rw_data",  64'(user_r_data), 64'('h100 + k));
        end
        cyc(0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0, 1);
            chk("empty_rd_level", 64'(level),       64'(0));
            chk("empty_rd_data",  64'(user_r_data), 64'('h105));
        end

        // close mid-frame, reopen reloads the frame, reset with words buffered
        cyc(0, 0, 8, 0, 0, 0);
        cyc(0, 1, 8, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 8, 1, DW'('h200 + i), 0);
        for (int i = 0; i < 3; i++)  cyc(0, 1, 8, 0, 0, 1);
        cyc(0, 0, 8, 0, 0, 0);
        chk("close_empty", 64'(user_r_empty), 64'(1));
        chk("close_eof",   64'(user_r_eof),   64'(0));
        cyc(0, 1, 8, 0, 0, 0);
        eof_cnt = 0;
        eof_data = '0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 8, 0, 0, 1);
            if (user_r_eof) begin eof_cnt++; eof_data = user_r_data; end
        end
        chk("reopen_eof_count", 64'(eof_cnt),  64'(1));
        chk("reopen_eof_data",  64'(eof_data), 64'('h20A));
        chk("reopen_level",     64'(level),    64'(1));
        for (int i = 0; i < 4; i++) cyc(0, 1, 8, 1, DW'('h300 + i), 0);
        chk("pre_reset_level", 64'(level), 64'(5));
        cyc(1, 1, 8, 0, 0, 0);
        chk("reset_level", 64'(level),        64'(0));
        chk("reset_empty", 64'(user_r_empty), 64'(1));
        cyc(0, 0, 0, 0, 0, 0);

        // randomized traffic against the model
        r_open = 1'b0;
        r_flen = '0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 19) == 0) r_open = ~r_open;
            if (!r_open) r_flen = FW'($urandom_range(0, 5));
            cyc($urandom_range(0, 199) == 0, r_open, r_flen,
                $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
